// File: rtl/parity_gen_chk.sv
// Pipelined parity generator/checker with a one-entry output register,
// a saturating mismatch counter and a sticky error flag.
module parity_gen_chk #(
    parameter int WIDTH   = 7,
    parameter int ODD_PAR = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    input  logic             clr_err
);

    localparam logic PAR_SENSE = (ODD_PAR != 0);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_par_q, out_par_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_sticky_q, err_sticky_d;

    logic par_calc;
    logic accept;
    logic xfer;
    logic mismatch;

    assign par_calc = (^in_data) ^ PAR_SENSE;
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    assign mismatch = accept && mode && (in_par != par_calc);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_par_d   = out_par_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_par_d   = mode ? in_par : par_calc;
            out_err_d   = mismatch;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // A clear never hides a mismatch arriving on the same edge.
    always_comb begin
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (clr_err) begin
            err_count_d  = mismatch ? CNT_W'(1) : '0;
            err_sticky_d = mismatch;
        end else if (mismatch) begin
            err_sticky_d = 1'b1;
            if (!(&err_count_q)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_par_q    <= 1'b0;
            out_err_q    <= 1'b0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_par_q    <= out_par_d;
            out_err_q    <= out_err_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_par    = out_par_q;
    assign out_err    = out_err_q;
    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Directed bench for parity_gen_chk: an even-parity CNT_W=2 instance
// and an odd-parity CNT_W=8 instance driven by the same stimulus.
module tb_parity_gen_chk;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_par;
    logic       mode;
    logic       out_ready;
    logic       clr_err;

    logic       r0, v0, p0, e0, s0;
    logic [6:0] d0;
    logic [1:0] c0;
    logic       r1, v1, p1, e1, s1;
    logic [6:0] d1;
    logic [7:0] c1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_gen_chk #(.WIDTH(7), .ODD_PAR(0), .CNT_W(2)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0),
        .in_data(in_data), .in_par(in_par), .mode(mode),
        .out_valid(v0), .out_ready(out_ready), .out_data(d0),
        .out_par(p0), .out_err(e0), .err_count(c0),
        .err_sticky(s0), .clr_err(clr_err)
    );

    parity_gen_chk #(.WIDTH(7), .ODD_PAR(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .in_par(in_par), .mode(mode),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .out_par(p1), .out_err(e1), .err_count(c1),
        .err_sticky(s1), .clr_err(clr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        in_par    = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({v0, d0, p0, e0, c0, s0, r0} !== {1'b0, 7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_dut0 got v%b d%h p%b e%b c%0d s%b r%b want all 0, ready 1",
                     v0, d0, p0, e0, c0, s0, r0);
        end
        checks++;
        if ({v1, d1, p1, e1, c1, s1, r1} !== {1'b0, 7'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_dut1 got v%b d%h p%b e%b c%0d s%b r%b want all 0, ready 1",
                     v1, d1, p1, e1, c1, s1, r1);
        end
    endtask

    task automatic test_gen_exhaustive();
        logic [6:0] w;
        logic       ep;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            w = 7'(i);
            ep = 1'b0;
            for (int b = 0; b < 7; b++) ep = ep ^ w[b];
            in_data = w;
            in_par  = ~ep;
            tick();
            checks++;
            if ({v0, d0, p0, e0, c0} !== {1'b1, w, ep, 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL gen_word %h got v%b d%h p%b e%b c%0d want v1 d%h p%b e0 c0",
                         w, v0, d0, p0, e0, c0, w, ep);
            end
            if (w == 7'h00 || w == 7'h07 || w == 7'h7F) begin
                checks++;
                if (p0 !== (w != 7'h00)) begin
                    errors++;
                    $display("FAIL gen_spot %h got par %b want %b", w, p0, (w != 7'h00));
                end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (v0 !== 1'b0 || s0 !== 1'b0) begin
            errors++;
            $display("FAIL gen_drain got v%b s%b want v0 s0", v0, s0);
        end
    endtask

    task automatic test_odd_check();
        do_reset();
        mode     = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'h03;
        in_par   = 1'b1;
        tick();
        checks++;
        if ({v1, d1, p1, e1, c1, s1} !== {1'b1, 7'h03, 1'b1, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL odd_match got v%b d%h p%b e%b c%0d s%b want v1 d03 p1 e0 c0 s0",
                     v1, d1, p1, e1, c1, s1);
        end
        in_par = 1'b0;
        tick();
        checks++;
        if ({v1, p1, e1, c1, s1} !== {1'b1, 1'b0, 1'b1, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL odd_mismatch got v%b p%b e%b c%0d s%b want v1 p0 e1 c1 s1",
                     v1, p1, e1, c1, s1);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        logic [6:0] w [4];
        logic       wp [4];
        logic [6:0] got [$];
        logic       gotp [$];
        int         n;
        w  = '{7'h15, 7'h2A, 7'h0F, 7'h41};
        wp = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        mode      = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = w[0];
        tick();
        in_data = w[1];
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({r0, v0, d0, p0, e0} !== {1'b0, 1'b1, w[0], wp[0], 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d got r%b v%b d%h p%b e%b want r0 v1 d%h p%b e0",
                         k, r0, v0, d0, p0, e0, w[0], wp[0]);
            end
            tick();
        end
        out_ready = 1'b1;
        n = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (v0 && out_ready) begin
                got.push_back(d0);
                gotp.push_back(p0);
            end
            if (n < 4) begin
                in_data = w[n];
                n++;
            end else begin
                in_valid = 1'b0;
            end
            if (!v0 && !in_valid) break;
            tick();
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL bp_count got %0d words want 4", got.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= got.size()) begin
                errors++;
                $display("FAIL bp_word%0d got none want %h", k, w[k]);
            end else if (got[k] !== w[k] || gotp[k] !== wp[k]) begin
                errors++;
                $display("FAIL bp_word%0d got %h/%b want %h/%b",
                         k, got[k], gotp[k], w[k], wp[k]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c;
        do_reset();
        mode     = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'h01;
        in_par   = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp_c = (k > 3) ? 2'd3 : 2'(k);
            tick();
            checks++;
            if ({c0, s0, e0} !== {exp_c, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL sat_inject%0d got c%0d s%b e%b want c%0d s1 e1",
                         k, c0, s0, e0, exp_c);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (c0 !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold got %0d want 3", c0);
        end
        clr_err = 1'b1;
        tick();
        checks++;
        if ({c0, s0} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL clr_alone got c%0d s%b want c0 s0", c0, s0);
        end
        in_valid = 1'b1;
        tick();
        checks++;
        if ({c0, s0, e0} !== {2'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL clr_with_err got c%0d s%b e%b want c1 s1 e1", c0, s0, e0);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        mode     = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'h01;
        in_par   = 1'b0;
        tick();
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        checks++;
        if ({v0, c0, r0} !== {1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL mid_pre got v%b c%0d r%b want v1 c2 r0", v0, c0, r0);
        end
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        clr_err   = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        checks++;
        if ({v0, d0, p0, e0, c0, s0, r0} !== {1'b0, 7'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset got v%b d%h p%b e%b c%0d s%b r%b want all 0, ready 1",
                     v0, d0, p0, e0, c0, s0, r0);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_mode_switch();
        // {mode, data, in_par, want out_par, want out_err}
        logic [10:0] vec [8];
        vec = '{
            {1'b0, 7'h15, 1'b0, 1'b1, 1'b0},
            {1'b1, 7'h15, 1'b0, 1'b0, 1'b1},
            {1'b0, 7'h0F, 1'b1, 1'b0, 1'b0},
            {1'b1, 7'h0F, 1'b0, 1'b0, 1'b0},
            {1'b0, 7'h7F, 1'b0, 1'b1, 1'b0},
            {1'b1, 7'h7F, 1'b1, 1'b1, 1'b0},
            {1'b0, 7'h00, 1'b1, 1'b0, 1'b0},
            {1'b1, 7'h00, 1'b1, 1'b1, 1'b1}
        };
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mode    = vec[k][10];
            in_data = vec[k][9:3];
            in_par  = vec[k][2];
            tick();
            checks++;
            if ({v0, d0, p0, e0} !== {1'b1, vec[k][9:3], vec[k][1], vec[k][0]}) begin
                errors++;
                $display("FAIL mode_sw%0d got v%b d%h p%b e%b want v1 d%h p%b e%b",
                         k, v0, d0, p0, e0, vec[k][9:3], vec[k][1], vec[k][0]);
            end
        end
        checks++;
        if ({c0, s0} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL mode_sw_count got c%0d s%b want c2 s1", c0, s0);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_gen_exhaustive();
        test_odd_check();
        test_backpressure();
        test_saturation();
        test_reset_midstream();
        test_mode_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_gen_chk.md
# parity_gen_chk

Parametrised, pipelined parity generator/checker for WIDTH-bit words. Consumes words over a valid/ready stream. In generate mode it appends a parity bit; in check mode it compares a supplied parity bit against the computed one and flags mismatches. It keeps a saturating error counter and a sticky error flag, and sits between a word source and any downstream consumer that needs parity-protected data.

## Interface
- WIDTH, 7, data word width in bits (≥1)
- ODD_PAR, 0, parity sense: 0 = even parity (bit = XOR of data), 1 = odd parity (bit = inverted XOR)
- CNT_W, 8, error counter width (≥1)

- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  input word
- in_par  input  1  supplied parity bit (used in check mode only)
- mode  input  1  0 = generate, 1 = check; sampled with each accepted word
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts output
- out_data  output  WIDTH  registered copy of accepted in_data
- out_par  output  1  generate: computed parity; check: the in_par that was received
- out_err  output  1  check-mode mismatch for the current output word; always 0 in generate mode
- err_count  output  CNT_W  saturating count of accepted check-mode mismatches
- err_sticky  output  1  set on any accepted mismatch
- clr_err  input  1  clears err_count and err_sticky

## Operation
- Computed parity: p = (XOR-reduce in_data) XOR ODD_PAR.
- Acceptance (accept) occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a one-entry output register with pass-through backpressure. No combinational path exists from in_valid to out_valid.
- On accept, the block loads the output register: out_data = in_data; out_valid = 1.
  - Generate mode: out_par = p; out_err = 0.
  - Check mode: out_par = in_par; out_err = (in_par != p).
- On a transfer with no accept in the same cycle, out_valid → 0. out_data, out_par and out_err hold their stale values.
- While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Error accounting happens only on accept with mode=1 and a mismatch:
  - err_count increments by 1 and saturates at 2^CNT_W−1 (no wrap).
  - err_sticky is set.
- clr_err has priority as a clear, but it does not mask a same-cycle mismatch. If clr_err coincides with an erroring accept, the block sets err_count = 1 and err_sticky = 1.
- mode may change on any cycle. Each word uses the mode present at its own accept.
- Reset values:
  - out_valid = 0, out_data = 0, out_par = 0, out_err = 0
  - err_count = 0, err_sticky = 0
  - in_ready = 1 on the first cycle after reset deasserts
- Reset mid-operation discards any held word without a transfer. Reset dominates clr_err, in_valid and out_ready.

## Timing
- Latency: 1 cycle. A word accepted at edge N is visible on out_* after edge N, and can transfer at edge N+1.
- Throughput: 1 word/cycle when out_ready is held high.
- err_count and err_sticky update on the same edge as the erroring accept, so they are visible with the corresponding out_err word.
- in_ready is combinational from out_valid and out_ready only.
- All state updates occur on the rising edge of clk. There are no latches and no asynchronous paths.

## Test plan
- Exhaustive generate: WIDTH=7, ODD_PAR=0, out_ready=1, mode=0, sweep in_data 0..127 one per cycle.
  - Required: each word appears 1 cycle later with out_par = popcount(in_data) mod 2.
  - Spot checks: 7'h00→0, 7'h07→1, 7'h7F→1.
  - out_err always 0; err_count stays 0.
- Check with ODD_PAR=1: mode=1, in_data=7'h03 with in_par=1 → out_err=0. in_data=7'h03 with in_par=0 → out_err=1, err_count=1, err_sticky=1.
- Backpressure: stream 4 words while out_ready=0 for 3 cycles.
  - Required: in_ready=0 while out_valid=1 and out_ready=0; out_* stable throughout.
  - After release: all 4 words delivered in order, none lost or duplicated.
- Saturation and clear, with CNT_W=2:
  - Inject 5 mismatches; err_count must read 3 and stay at 3.
  - Assert clr_err alone: count 0, sticky 0.
  - Assert clr_err together with a mismatching accept: count 1, sticky 1.
- Reset mid-stream: assert reset while out_valid=1, out_ready=0 and err_count=2.
  - Next cycle: out_valid=0, out_data=0, out_par=0, out_err=0, err_count=0, err_sticky=0, in_ready=1.
- Mode switching: alternate mode 0/1 every word on a continuous stream with out_ready=1.
  - Required: out_err is asserted only on check-mode mismatches.
  - In generate mode out_par = p; in check mode out_par = in_par.
